// File: rtl/ingress_arbiter_pkg.sv
// Shared types, port-code constants and tag encoders for the ingress arbiter.
// Port codes: PF (x,y) -> x*4+y, CMAC x -> 8+x, 4'hF means "let the pipeline resolve".
package ingress_arbiter_pkg;

    localparam int DATA_W = 512;
    localparam int KEEP_W = 64;
    localparam int USER_W = 16;
    localparam int PORT_W = 4;

    localparam logic [PORT_W-1:0] PORT_NONE = 4'hF;
    localparam logic [PORT_W-1:0] CMAC_BASE = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [PORT_W-1:0] encode_ingress_port(input logic is_cmac,
                                                              input int unsigned x,
                                                              input int unsigned y);
        if (is_cmac) begin
            return CMAC_BASE + PORT_W'(x);
        end
        return PORT_W'(x * 4 + y);
    endfunction

    // Host destinations are one-hot in the low nibble and land on the QDMA of the requester.
    function automatic logic [PORT_W-1:0] encode_egress_port(input logic [USER_W-1:0] dst,
                                                             input logic on_qdma1);
        logic [PORT_W-1:0] code;
        code = PORT_NONE;
        if (dst[15:4] == 12'd0) begin
            for (int b = 0; b < 4; b++) begin
                if (dst[3:0] == 4'(1 << b)) begin
                    code = PORT_W'(b) + (on_qdma1 ? 4'd4 : 4'd0);
                end
            end
        end else if (dst == 16'h0010) begin
            code = CMAC_BASE;
        end else if (dst == 16'h0020) begin
            code = CMAC_BASE + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/ingress_arbiter_rr.sv
// Combinational round-robin pick: first requester after last_grant_i, wrapping.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_grant_i,
    output logic [N-1:0]         grant_oh_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 any_req_o
);
    localparam int IW = $clog2(N);

    int cand;

    always_comb begin
        grant_idx_o = '0;
        cand        = 0;
        any_req_o   = |req_i;
        // Scan farthest-first so the nearest eligible requester is the last to write.
        for (int k = N; k >= 1; k--) begin
            cand = (int'(last_grant_i) + k) % N;
            if ((req_i & (N'(1) << cand)) != '0) begin
                grant_idx_o = IW'(cand);
            end
        end
        grant_oh_o = any_req_o ? (N'(1) << grant_idx_o) : '0;
    end

endmodule

// File: rtl/ingress_arbiter.sv
// Packet-granular round-robin arbiter in front of the VNP4 pipeline: locks one
// requester per packet and tags its first beat with size, ingress and egress port.
module ingress_arbiter
    import ingress_arbiter_pkg::*;
#(
    parameter int NUM_QDMA      = 1,
    parameter int NUM_PHYS_FUNC = 1,
    parameter int NUM_CMAC_PORT = 1
) (
    input  logic                                                 aclk,
    input  logic                                                 areset,
    input  logic [NUM_QDMA*NUM_PHYS_FUNC-1:0]                    s_axis_pf_tvalid,
    input  logic [NUM_QDMA*NUM_PHYS_FUNC-1:0][DATA_W-1:0]        s_axis_pf_tdata,
    input  logic [NUM_QDMA*NUM_PHYS_FUNC-1:0][KEEP_W-1:0]        s_axis_pf_tkeep,
    input  logic [NUM_QDMA*NUM_PHYS_FUNC-1:0]                    s_axis_pf_tlast,
    input  logic [NUM_QDMA*NUM_PHYS_FUNC-1:0][USER_W-1:0]        s_axis_pf_tuser_size,
    input  logic [NUM_QDMA*NUM_PHYS_FUNC-1:0][USER_W-1:0]        s_axis_pf_tuser_dst,
    output logic [NUM_QDMA*NUM_PHYS_FUNC-1:0]                    s_axis_pf_tready,
    input  logic [NUM_CMAC_PORT-1:0]                             s_axis_cmac_tvalid,
    input  logic [NUM_CMAC_PORT-1:0][DATA_W-1:0]                 s_axis_cmac_tdata,
    input  logic [NUM_CMAC_PORT-1:0][KEEP_W-1:0]                 s_axis_cmac_tkeep,
    input  logic [NUM_CMAC_PORT-1:0]                             s_axis_cmac_tlast,
    input  logic [NUM_CMAC_PORT-1:0][USER_W-1:0]                 s_axis_cmac_tuser_size,
    input  logic [NUM_CMAC_PORT-1:0][USER_W-1:0]                 s_axis_cmac_tuser_dst,
    output logic [NUM_CMAC_PORT-1:0]                             s_axis_cmac_tready,
    output logic [DATA_W-1:0]                                    m_axis_tdata,
    output logic [KEEP_W-1:0]                                    m_axis_tkeep,
    output logic                                                 m_axis_tlast,
    output logic                                                 m_axis_tvalid,
    input  logic                                                 m_axis_tready,
    output logic                                                 m_axis_tuser_valid,
    output logic [USER_W-1:0]                                    m_axis_tuser_size,
    output logic [PORT_W-1:0]                                    m_axis_tuser_ingress_port,
    output logic [PORT_W-1:0]                                    m_axis_tuser_egress_port,
    input  logic [NUM_QDMA*NUM_PHYS_FUNC+NUM_CMAC_PORT-1:0]      port_enable,
    output logic                                                 busy,
    output logic [3:0]                                           grant_id,
    output state_t                                               dbg_state
);
    localparam int NPF = NUM_QDMA * NUM_PHYS_FUNC;
    localparam int N   = NPF + NUM_CMAC_PORT;
    localparam int IW  = $clog2(N);

    // Valid/ready: a beat moves on a clock edge where both valid and ready are high;
    // the granted requester's ready mirrors m_axis_tready, every other ready stays low.
    logic [N-1:0]        req_valid, req_last, req_ready, req_q1;
    logic [DATA_W-1:0]   req_data [N];
    logic [KEEP_W-1:0]   req_keep [N];
    logic [USER_W-1:0]   req_size [N];
    logic [USER_W-1:0]   req_dst  [N];
    logic [PORT_W-1:0]   req_ing  [N];

    for (genvar i = 0; i < NPF; i++) begin : g_pf
        assign req_valid[i]        = s_axis_pf_tvalid[i];
        assign req_last[i]         = s_axis_pf_tlast[i];
        assign req_data[i]         = s_axis_pf_tdata[i];
        assign req_keep[i]         = s_axis_pf_tkeep[i];
        assign req_size[i]         = s_axis_pf_tuser_size[i];
        assign req_dst[i]          = s_axis_pf_tuser_dst[i];
        assign req_ing[i]          = encode_ingress_port(1'b0, i / NUM_PHYS_FUNC, i % NUM_PHYS_FUNC);
        assign req_q1[i]           = ((i / NUM_PHYS_FUNC) == 1);
        assign s_axis_pf_tready[i] = req_ready[i];
    end

    for (genvar i = 0; i < NUM_CMAC_PORT; i++) begin : g_cmac
        assign req_valid[NPF+i]      = s_axis_cmac_tvalid[i];
        assign req_last[NPF+i]       = s_axis_cmac_tlast[i];
        assign req_data[NPF+i]       = s_axis_cmac_tdata[i];
        assign req_keep[NPF+i]       = s_axis_cmac_tkeep[i];
        assign req_size[NPF+i]       = s_axis_cmac_tuser_size[i];
        assign req_dst[NPF+i]        = s_axis_cmac_tuser_dst[i];
        assign req_ing[NPF+i]        = encode_ingress_port(1'b1, i, 0);
        assign req_q1[NPF+i]         = 1'b0;
        assign s_axis_cmac_tready[i] = req_ready[NPF+i];
    end

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d, last_grant_q, last_grant_d;
    logic [N-1:0]    grant_oh_q, grant_oh_d;
    logic            first_beat_q, first_beat_d;

    logic [N-1:0]    arb_oh;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arbiter #(.N(N)) u_rr (
        .req_i        (req_valid & port_enable),
        .last_grant_i (last_grant_q),
        .grant_oh_o   (arb_oh),
        .grant_idx_o  (arb_idx),
        .any_req_o    (arb_any)
    );

    logic                sel_valid, sel_last, sel_q1;
    logic [DATA_W-1:0]   sel_data;
    logic [KEEP_W-1:0]   sel_keep;
    logic [USER_W-1:0]   sel_size, sel_dst;
    logic [PORT_W-1:0]   sel_ing;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_q1    = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_size  = '0;
        sel_dst   = '0;
        sel_ing   = '0;
        for (int r = 0; r < N; r++) begin
            if (grant_oh_q[r]) begin
                sel_valid = req_valid[r];
                sel_last  = req_last[r];
                sel_q1    = req_q1[r];
                sel_data  = req_data[r];
                sel_keep  = req_keep[r];
                sel_size  = req_size[r];
                sel_dst   = req_dst[r];
                sel_ing   = req_ing[r];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_oh_d   = grant_oh_q;
        last_grant_d = last_grant_q;
        first_beat_d = first_beat_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d      = BUSY;
                    grant_d      = arb_idx;
                    grant_oh_d   = arb_oh;
                    first_beat_d = 1'b1;
                end
            end
            BUSY: begin
                if (sel_valid && m_axis_tready) begin
                    first_beat_d = 1'b0;
                    if (sel_last) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant starts at N-1 so requester 0 wins the first arbitration.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_oh_q   <= '0;
            last_grant_q <= IW'(N - 1);
            first_beat_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_oh_q   <= grant_oh_d;
            last_grant_q <= last_grant_d;
            first_beat_q <= first_beat_d;
        end
    end

    assign busy                      = (state_q == BUSY);
    assign m_axis_tvalid             = busy && sel_valid;
    assign m_axis_tdata              = sel_data;
    assign m_axis_tkeep              = sel_keep;
    assign m_axis_tlast              = sel_last;
    assign m_axis_tuser_valid        = busy && first_beat_q && sel_valid;
    assign m_axis_tuser_size         = sel_size;
    assign m_axis_tuser_ingress_port = sel_ing;
    assign m_axis_tuser_egress_port  = encode_egress_port(sel_dst, sel_q1);
    assign req_ready                 = (busy && m_axis_tready) ? grant_oh_q : '0;
    assign grant_id                  = 4'(grant_q);
    assign dbg_state                 = state_q;

endmodule

// File: tb/tb_ingress_arbiter.sv
// Bench for ingress_arbiter with 2 QDMA x 4 PF + 1 CMAC (9 requesters).
module tb_ingress_arbiter;
    import ingress_arbiter_pkg::*;

    localparam int NQ  = 2;
    localparam int NPF = 4;
    localparam int NC  = 1;
    localparam int NP  = NQ * NPF;
    localparam int N   = NP + NC;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic [15:0]  size;
        logic [15:0]  dst;
    } src_t;

    typedef struct packed {
        logic [3:0]   req;
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic         uv;
        logic [15:0]  size;
        logic [3:0]   ing;
        logic [3:0]   egr;
    } exp_t;

    localparam int EW = $bits(exp_t);

    typedef struct {
        int          req;
        logic [15:0] dst;
        logic [3:0]  ing;
        logic [3:0]  egr;
    } vec_t;

    // clock / reset
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic areset;

    logic [N-1:0]             r_valid, r_last, r_ready;
    logic [N-1:0][511:0]      r_data;
    logic [N-1:0][63:0]       r_keep;
    logic [N-1:0][15:0]       r_size, r_dst;
    logic [NP-1:0]            pf_ready;
    logic [NC-1:0]            cm_ready;
    logic [511:0]             m_tdata;
    logic [63:0]              m_tkeep;
    logic                     m_tlast, m_tvalid, m_tready, m_uvalid;
    logic [15:0]              m_usize;
    logic [3:0]               m_ing, m_egr;
    logic [N-1:0]             port_enable;
    logic                     busy;
    logic [3:0]               grant_id;
    state_t                   dbg_state;

    assign r_ready = {cm_ready, pf_ready};

    ingress_arbiter #(.NUM_QDMA(NQ), .NUM_PHYS_FUNC(NPF), .NUM_CMAC_PORT(NC)) dut (
        .aclk                      (aclk),
        .areset                    (areset),
        .s_axis_pf_tvalid          (r_valid[NP-1:0]),
        .s_axis_pf_tdata           (r_data[NP-1:0]),
        .s_axis_pf_tkeep           (r_keep[NP-1:0]),
        .s_axis_pf_tlast           (r_last[NP-1:0]),
        .s_axis_pf_tuser_size      (r_size[NP-1:0]),
        .s_axis_pf_tuser_dst       (r_dst[NP-1:0]),
        .s_axis_pf_tready          (pf_ready),
        .s_axis_cmac_tvalid        (r_valid[N-1:NP]),
        .s_axis_cmac_tdata         (r_data[N-1:NP]),
        .s_axis_cmac_tkeep         (r_keep[N-1:NP]),
        .s_axis_cmac_tlast         (r_last[N-1:NP]),
        .s_axis_cmac_tuser_size    (r_size[N-1:NP]),
        .s_axis_cmac_tuser_dst     (r_dst[N-1:NP]),
        .s_axis_cmac_tready        (cm_ready),
        .m_axis_tdata              (m_tdata),
        .m_axis_tkeep              (m_tkeep),
        .m_axis_tlast              (m_tlast),
        .m_axis_tvalid             (m_tvalid),
        .m_axis_tready             (m_tready),
        .m_axis_tuser_valid        (m_uvalid),
        .m_axis_tuser_size         (m_usize),
        .m_axis_tuser_ingress_port (m_ing),
        .m_axis_tuser_egress_port  (m_egr),
        .port_enable               (port_enable),
        .busy                      (busy),
        .grant_id                  (grant_id),
        .dbg_state                 (dbg_state)
    );

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    int            obs_grant[$];
    logic [3:0]    obs_ing, obs_egr;
    src_t          src_mem [N][32];
    int            src_cnt [N];
    int            src_head[N];
    int            mdl_head[N];
    int            model_last;
    int            total, bad;
    vec_t          vecs[10];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: port codes straight from the port map
    function automatic logic [3:0] ref_ingress(input int r);
        if (r < NP) return 4'((r / NPF) * 4 + (r % NPF));
        return 4'(8 + r - NP);
    endfunction

    function automatic logic [3:0] ref_egress(input int r, input logic [15:0] dst);
        logic [3:0] base;
        base = (r < NP && (r / NPF) == 1) ? 4'd4 : 4'd0;
        case (dst)
            16'h0001: return base;
            16'h0002: return base + 4'd1;
            16'h0004: return base + 4'd2;
            16'h0008: return base + 4'd3;
            16'h0010: return 4'd8;
            16'h0020: return 4'd9;
            default:  return 4'hF;
        endcase
    endfunction

    task automatic clear_src();
        for (int r = 0; r < N; r++) begin
            src_cnt[r]  = 0;
            src_head[r] = 0;
            mdl_head[r] = 0;
        end
        exp_q.delete();
        obs_grant.delete();
    endtask

    task automatic add_packet(input int r, input int beats, input logic [15:0] dst, input logic [15:0] size);
        src_t s;
        for (int b = 0; b < beats; b++) begin
            for (int w = 0; w < 16; w++) s.data[w*32 +: 32] = $urandom;
            s.data[511:500] = {4'(r), 8'(src_cnt[r])};
            s.keep = {$urandom, $urandom};
            s.last = (b == beats - 1);
            s.size = size;
            s.dst  = dst;
            if (src_cnt[r] < 32) begin
                src_mem[r][src_cnt[r]] = s;
                src_cnt[r]++;
            end
        end
    endtask

    // Packet-level round robin over requesters that still hold packets and are enabled.
    task automatic model_pick(input logic [N-1:0] en, output bit ok);
        exp_t e;
        src_t s;
        int   r;
        bit   first;
        ok = 0;
        for (int k = 1; k <= N && !ok; k++) begin
            r = (model_last + k) % N;
            if (en[r] && mdl_head[r] < src_cnt[r]) begin
                ok    = 1;
                first = 1;
                s     = src_mem[r][mdl_head[r]];
                e.size = s.size;
                e.ing  = ref_ingress(r);
                e.egr  = ref_egress(r, s.dst);
                do begin
                    s      = src_mem[r][mdl_head[r]];
                    e.req  = 4'(r);
                    e.data = s.data;
                    e.keep = s.keep;
                    e.last = s.last;
                    e.uv   = first;
                    exp_q.push_back(e);
                    first  = 0;
                    mdl_head[r]++;
                end while (!s.last);
                model_last = r;
            end
        end
    endtask

    task automatic build_model(input logic [N-1:0] en);
        bit ok;
        ok = 1;
        while (ok) model_pick(en, ok);
    endtask

    // drivers
    task automatic drive_src();
        src_t s;
        for (int r = 0; r < N; r++) begin
            if (src_head[r] < src_cnt[r]) begin
                s = src_mem[r][src_head[r]];
                r_valid[r] = 1'b1;
                r_data[r]  = s.data;
                r_keep[r]  = s.keep;
                r_last[r]  = s.last;
                r_size[r]  = s.size;
                r_dst[r]   = s.dst;
            end else begin
                r_valid[r] = 1'b0;
                r_data[r]  = '0;
                r_keep[r]  = '0;
                r_last[r]  = 1'b0;
                r_size[r]  = '0;
                r_dst[r]   = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_src();
        drive_src();
        m_tready    = 1'b0;
        port_enable = '1;
        repeat (2) @(posedge aclk);
        #1;
        areset     = 1'b0;
        model_last = N - 1;
    endtask

    // Drives all queued beats, checks every output handshake against exp_q.
    task automatic run(input int mode, input int dis_req, input int dis_after, input int tail);
        int           cyc, hs, since_last;
        logic         stalled, hs_now;
        logic [511:0] stall_data;
        logic [3:0]   owner;
        exp_t         e;
        cyc = 0; hs = 0; since_last = 0; stalled = 0; stall_data = '0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            drive_src();
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(0, 3) != 0);
                default: m_tready = (cyc % 2 == 1);
            endcase
            if (dis_req >= 0 && hs >= dis_after) port_enable[dis_req] = 1'b0;
            #1;
            e     = exp_q[0];
            owner = e.req;
            check("ready_isolation", r_ready & ~(N'(1) << owner), '0);
            if (stalled) begin
                check("stall_valid", m_tvalid, 1'b1);
                check("stall_data", m_tdata, stall_data);
            end
            if (since_last == 1) begin
                check("bubble_valid", m_tvalid, 1'b0);
                check("bubble_busy", busy, 1'b0);
            end else if (since_last == 2) begin
                check("next_first_beat", m_tvalid, 1'b1);
            end
            hs_now = m_tvalid && m_tready;
            if (hs_now) begin
                void'(exp_q.pop_front());
                check("beat_data", m_tdata, e.data);
                check("beat_keep", m_tkeep, e.keep);
                check("beat_last", m_tlast, e.last);
                check("beat_user_valid", m_uvalid, e.uv);
                check("beat_grant_id", grant_id, e.req);
                check("beat_owner_ready", r_ready[owner], 1'b1);
                if (e.uv) begin
                    check("first_size", m_usize, e.size);
                    check("first_ingress", m_ing, e.ing);
                    check("first_egress", m_egr, e.egr);
                    obs_grant.push_back(int'(grant_id));
                    obs_ing = m_ing;
                    obs_egr = m_egr;
                end
                hs++;
            end
            stalled    = m_tvalid && !m_tready;
            stall_data = m_tdata;
            for (int r = 0; r < N; r++) begin
                if (r_valid[r] && r_ready[r]) src_head[r]++;
            end
            if (hs_now && e.last) since_last = 1;
            else if (since_last > 0) since_last = (since_last == 2) ? 0 : since_last + 1;
            step();
            cyc++;
        end
        check("run_within_budget", cyc < 3000, 1'b1);
        repeat (tail) begin
            drive_src();
            #1;
            check("tail_idle_valid", m_tvalid, 1'b0);
            check("tail_idle_ready", r_ready, '0);
            step();
        end
    endtask

    initial begin
        logic [15:0] dst_pool[9];
        total = 0;
        bad   = 0;
        dst_pool = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010,
                     16'h0020, 16'h0003, 16'h0000, 16'h0101};
        vecs[0] = '{0, 16'h0010, 4'd0, 4'd8};
        vecs[1] = '{6, 16'h0001, 4'd6, 4'd4};
        vecs[2] = '{0, 16'h0003, 4'd0, 4'hF};
        vecs[3] = '{8, 16'h0020, 4'd8, 4'd9};
        vecs[4] = '{5, 16'h0004, 4'd5, 4'd6};
        vecs[5] = '{3, 16'h0008, 4'd3, 4'd3};
        vecs[6] = '{8, 16'h0002, 4'd8, 4'd1};
        vecs[7] = '{2, 16'h0000, 4'd2, 4'hF};
        vecs[8] = '{7, 16'h0110, 4'd7, 4'hF};
        vecs[9] = '{4, 16'h0001, 4'd4, 4'd4};

        // reset values
        do_reset();
        areset = 1'b1;
        #1;
        check("rst_valid", m_tvalid, 1'b0);
        check("rst_user_valid", m_uvalid, 1'b0);
        check("rst_readies", r_ready, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 4'd0);
        check("rst_state", dbg_state, IDLE);
        areset = 1'b0;
        step();

        // single PF0 packet, 3 beats
        clear_src();
        add_packet(0, 3, 16'h0010, 16'd192);
        build_model('1);
        run(0, -1, 0, 2);
        check("pf0_ingress", obs_ing, 4'd0);
        check("pf0_egress", obs_egr, 4'd8);

        // tag table, single-beat packets
        foreach (vecs[i]) begin
            clear_src();
            add_packet(vecs[i].req, 1, vecs[i].dst, 16'(64 + i));
            build_model('1);
            run(0, -1, 0, 2);
            check("tbl_ingress", obs_ing, vecs[i].ing);
            check("tbl_egress", obs_egr, vecs[i].egr);
        end

        // all requesters busy, 2-beat packets: grants must cycle 0..N-1 twice
        do_reset();
        for (int r = 0; r < N; r++) begin
            add_packet(r, 2, 16'h0001, 16'd128);
            add_packet(r, 2, 16'h0002, 16'd128);
        end
        build_model('1);
        run(0, -1, 0, 2);
        check("rr_count", obs_grant.size(), 2 * N);
        for (int k = 0; k < obs_grant.size(); k++) check("rr_order", obs_grant[k], k % N);

        // CMAC0 4-beat packet with ready toggling 1010
        clear_src();
        add_packet(8, 4, 16'h0020, 16'd256);
        build_model('1);
        run(2, -1, 0, 2);
        check("cmac_ingress", obs_ing, 4'd8);

        // randomized traffic, chained without reset
        for (int round = 0; round < 6; round++) begin
            clear_src();
            for (int r = 0; r < N; r++) begin
                for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                    add_packet(r, $urandom_range(1, 4), dst_pool[$urandom_range(0, 8)], 16'($urandom));
                end
            end
            build_model('1);
            run(1, -1, 0, 2);
        end

        // port_enable[1] dropped mid-packet: packet completes, later rounds skip requester 1
        do_reset();
        add_packet(1, 3, 16'h0004, 16'd192);
        add_packet(1, 2, 16'h0004, 16'd128);
        add_packet(2, 2, 16'h0008, 16'd128);
        begin
            bit ok;
            model_pick('1, ok);
        end
        build_model(~(N'(1) << 1));
        run(0, 1, 1, 6);
        check("disable_grants", obs_grant.size(), 2);
        if (obs_grant.size() == 2) begin
            check("disable_first", obs_grant[0], 1);
            check("disable_second", obs_grant[1], 2);
        end
        port_enable = '1;

        // async reset on beat 2 of a 4-beat packet
        do_reset();
        add_packet(0, 4, 16'h0001, 16'd256);
        m_tready = 1'b1;
        drive_src();
        #1;
        check("ar_arb_bubble", m_tvalid, 1'b0);
        step();
        drive_src();
        #1;
        check("ar_beat1_valid", m_tvalid, 1'b1);
        check("ar_beat1_uvalid", m_uvalid, 1'b1);
        for (int r = 0; r < N; r++) if (r_valid[r] && r_ready[r]) src_head[r]++;
        step();
        drive_src();
        #1;
        check("ar_beat2_valid", m_tvalid, 1'b1);
        areset = 1'b1;
        #1;
        check("ar_valid_drop", m_tvalid, 1'b0);
        check("ar_ready_drop", r_ready, '0);
        check("ar_uvalid_drop", m_uvalid, 1'b0);
        check("ar_busy_drop", busy, 1'b0);
        check("ar_grant_drop", grant_id, 4'd0);
        do_reset();
        add_packet(5, 2, 16'h0002, 16'd128);
        add_packet(0, 2, 16'h0001, 16'd128);
        build_model('1);
        run(0, -1, 0, 2);
        check("ar_first_winner", (obs_grant.size() > 0) ? obs_grant[0] : -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ingress_arbiter.md
# ingress_arbiter

Packet-granular round-robin arbiter that shares the single VNP4 pipeline input stream among all host-side (QDMA physical function) and line-side (CMAC) requesters. It sits in the 250 MHz shared TX/RX plugin, upstream of the P4 pipeline, which feeds the egress switch. For each packet it locks one requester, forwards beats unmodified, and tags the first beat with size, ingress port and a pre-resolved egress port.

## Interface
Parameters:
- NUM_QDMA, 1: QDMA instances (1..2).
- NUM_PHYS_FUNC, 1: physical functions per QDMA (1..4).
- NUM_CMAC_PORT, 1: CMAC ports (1..2).

Ports:
- aclk  in  1  sole clock.
- areset  in  1  asynchronous, active-high reset.
- s_axis_pf  axi_stream_if.slave  [NUM_QDMA*NUM_PHYS_FUNC]  host requesters; data 512, keep 64, user_size/src/dst 16 each.
- s_axis_cmac  axi_stream_if.slave  [NUM_CMAC_PORT]  line requesters, same fields.
- m_axis  axi_stream_vnp4_if.master  1  to pipeline: data, keep, last, valid, ready, user_valid, user_size 16, user_ingress_port, user_egress_port.
- port_enable  in  N  per-requester enable, N = NUM_QDMA*NUM_PHYS_FUNC+NUM_CMAC_PORT; PF requesters first, then CMAC.
- busy  out  1  high while a packet is locked.
- grant_id  out  4  requester index of current or last grant.

## Operation
- Requester index r: PF (x,y) → x*NUM_PHYS_FUNC+y; CMAC x → NUM_QDMA*NUM_PHYS_FUNC+x.
- Ingress port code: PF (x,y) → x*4+y; CMAC x → 8+x.
- Egress port code from the first-beat user_dst: one-hot bits [3:0] with [15:4]=0 → 0..3, offset +4 if the requester is on QDMA 1; bit 4 alone → 8; bit 5 alone → 9; any other value → 4'hF (pipeline resolves).
- States: IDLE, BUSY.
- IDLE: eligible = valid & port_enable. If none, stay. Otherwise the round-robin winner is the first eligible index after last_grant, cyclically. Register grant, set first_beat=1, go to BUSY. No beat transfers in IDLE.
- BUSY:
  - m_axis data/keep/last/valid = granted requester's; granted ready = m_axis.ready; all other readies 0.
  - user_valid = first_beat & valid; user_size, user_ingress_port, user_egress_port are driven from the granted requester on that beat.
  - first_beat clears on the first handshake.
  - On a handshake with last=1: last_grant ← grant, go to IDLE.
- Deasserting port_enable mid-packet does not abort the packet; it only affects the next arbitration.
- Single-beat packet: user_valid and last are high on the same beat.

## Timing
- Reset values: state IDLE, m_axis.valid 0, user_valid 0, all s_axis ready 0, busy 0, grant_id 0, last_grant N-1 (requester 0 wins first), first_beat 0.
- Arbitration costs one cycle. The first beat is presented on the cycle after valid is seen in IDLE.
- Back-to-back packets have exactly one idle cycle between the last beat and the next first beat.
- Forward path inside BUSY is combinational (0 cycles). m_axis fields are stable while valid & !ready because the grant is locked.
- A requester that holds valid low mid-packet stalls m_axis. No timeout.
- Async reset mid-packet: outputs drop to reset values immediately and the partial packet is truncated. Upstream must also be reset.

## Structure
- Package ingress_arbiter_pkg:
  - port code constants (PORT_NONE=4'hF, CMAC_BASE=8);
  - encode_ingress_port and encode_egress_port functions;
  - state_t enum {IDLE, BUSY}.
- Sub-module rr_arbiter #(N): request vector and last_grant in; one-hot grant, index and any_req out; purely combinational.
- Top: interface flattening generate loops, FSM, first_beat flag, output mux.

## Test plan
- Single PF0 packet: 3 beats, user_size 192, user_dst 16'h0010 → one arbitration bubble; beat 1 has user_valid=1, ingress 0, egress 8; beats 2–3 have user_valid=0; busy falls after last.
- All N requesters continuously valid, 2-beat packets → grants cycle 0,1,…,N-1,0; each packet followed by one idle cycle; no interleaving.
- m_axis.ready toggles 1010 during a 4-beat CMAC0 packet → data stable across stalls; other readies stay 0; ingress 8.
- Invalid user_dst 16'h0003, and QDMA1 PF2 with user_dst 16'h0001 → egress 4'hF and 4 respectively; ingress of the QDMA1 PF2 packet is 6.
- port_enable[1] cleared mid-packet from requester 1 → packet completes; requester 1 is skipped on later rounds while still valid.
- areset asserted on beat 2 of 4 → m_axis.valid and all readies are 0 in the same cycle; after release, requester 0 wins first.
